// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: CU branch codes, FSM states and
// a small field-extension helper.
package pc_fetch_unit_pkg;

  // Next-PC select codes driven by the control unit
  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;
  localparam logic [1:0] BR_JREG = 2'b11;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch unit
// (master) and the instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection from the CU branch code, plus the
// word-alignment check on the chosen target.
module pc_fetch_unit_next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  branch,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] seq_pc_s;
  logic        unused_opcode_s;

  assign seq_pc_s        = pc + 32'd4;
  // Opcode bits are decoded by the CU, not here
  assign unused_opcode_s = ^instr[31:26];

  // Select the target; all arithmetic wraps mod 2^32
  always_comb begin
    next_pc = seq_pc_s;
    case (branch)
      BR_SEQ:  next_pc = seq_pc_s;
      BR_COND: next_pc = seq_pc_s + (sext16(instr[15:0]) << 2);
      BR_JUMP: next_pc = {seq_pc_s[31:28], instr[25:0], 2'b00};
      BR_JREG: next_pc = reg_target;
      default: next_pc = seq_pc_s;
    endcase
  end

  // Only a register target can actually produce low bits, but check all
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage. Fetches one word per
// instruction over a variable-latency handshake, holds it for issue, and
// advances the PC from the CU branch code when the core retires it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_unit_if.master    imem,
  input  logic               stall,
  input  logic [1:0]         branch,
  input  logic [31:0]        reg_target,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               err,
  output logic               halted
);

  // Last counter value before the timeout fires (only used when enabled)
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT) - 32'd1;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] cnt_r;
  logic        req_r;
  logic        iv_r;
  logic        err_r;
  logic        halted_r;

  logic [31:0] next_pc_s;
  logic        misaligned_s;
  logic        timeout_hit_s;

  pc_fetch_unit_next_pc_calc u_next_pc (
    .pc         (pc_r),
    .instr      (instr_r),
    .branch     (branch),
    .reg_target (reg_target),
    .next_pc    (next_pc_s),
    .misaligned (misaligned_s)
  );

  // Timeout fires on the FETCH cycle that would bring the counter to TIMEOUT
  always_comb begin
    timeout_hit_s = 1'b0;
    if (TIMEOUT != 32'd0) begin
      timeout_hit_s = (cnt_r == TIMEOUT_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Fetch FSM with all outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC;
      instr_r  <= 32'h0000_0000;
      cnt_r    <= 32'd0;
      req_r    <= 1'b0;
      iv_r     <= 1'b0;
      err_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b1;
          cnt_r   <= 32'd0;
        end
        ST_FETCH: begin
          if (imem.imem_valid) begin
            instr_r <= imem.imem_rdata;
            cnt_r   <= 32'd0;
            req_r   <= 1'b0;
            iv_r    <= 1'b1;
            state_r <= ST_ISSUE;
          end else if (timeout_hit_s) begin
            err_r    <= 1'b1;
            halted_r <= 1'b1;
            req_r    <= 1'b0;
            state_r  <= ST_HALT;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            if (misaligned_s) begin
              // PC keeps the address of the offending instruction
              err_r    <= 1'b1;
              halted_r <= 1'b1;
              iv_r     <= 1'b0;
              state_r  <= ST_HALT;
            end else begin
              pc_r    <= next_pc_s;
              iv_r    <= 1'b0;
              req_r   <= 1'b1;
              cnt_r   <= 32'd0;
              state_r <= ST_FETCH;
            end
          end else begin
            iv_r <= 1'b1;
          end
        end
        ST_HALT: begin
          req_r    <= 1'b0;
          iv_r     <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into HALT
          req_r    <= 1'b0;
          iv_r     <= 1'b0;
          err_r    <= 1'b1;
          halted_r <= 1'b1;
          state_r  <= ST_HALT;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = iv_r;
  assign pc             = pc_r;
  assign pc_plus4       = pc_r + 32'd4;
  assign err            = err_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vectors, stall/misalign/
// reset/timeout sequences, and a randomized run against an address model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  branch;
  logic [31:0] reg_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        err;
  logic        halted;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall       (stall),
    .branch      (branch),
    .reg_target  (reg_target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .err         (err),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory model controls
  bit          mem_en      = 1'b1;
  int          lat         = 0;
  int          wcnt        = 0;
  bit          force_valid = 1'b0;
  logic [31:0] force_word  = 32'h0;
  bit          ovr_en      = 1'b0;
  logic [31:0] ovr_addr    = 32'h0;
  logic [31:0] ovr_word    = 32'h0;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Cycles the current request has been waiting
  always @(posedge clk) begin
    if (!imem_bus.imem_req || imem_bus.imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign imem_bus.imem_valid = force_valid | (mem_en & imem_bus.imem_req & (wcnt >= lat));
  assign imem_bus.imem_rdata = force_valid ? force_word :
                               (ovr_en && imem_bus.imem_addr == ovr_addr) ? ovr_word :
                               hashw(imem_bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  // Retire the issued instruction after ns stall cycles; returns one negedge after commit
  task automatic retire(input logic [1:0] br, input logic [31:0] rt, input int ns);
    logic [31:0] p0;
    logic [31:0] i0;
    p0 = pc;
    i0 = instr;
    branch = br;
    reg_target = rt;
    for (int k = 0; k < ns; k++) begin
      stall = 1'b1;
      @(negedge clk);
      chk("stall_iv", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, p0);
      chk("stall_instr", instr, i0);
      chk("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    // Junk on the CU inputs must be ignored outside ISSUE
    branch = 2'($urandom);
    reg_target = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  br;
    logic [31:0] rt;
    logic [31:0] exp_pp4;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] model_pc;
    logic [31:0] exp;
    logic [31:0] iw;
    logic [31:0] p0;
    logic signed [31:0] off;
    logic [1:0]  br;
    logic [31:0] rt;

    vecs[0] = '{32'h0000_0100, 32'h0000_FFFE, 2'b01, 32'h0, 32'h0000_0104, 32'h0000_00FC};
    vecs[1] = '{32'h0000_0100, 32'h0000_0003, 2'b01, 32'h0, 32'h0000_0104, 32'h0000_0110};
    vecs[2] = '{32'hF000_0010, 32'h0000_0040, 2'b10, 32'h0, 32'hF000_0014, 32'hF000_0100};
    vecs[3] = '{32'h0000_0100, 32'h0000_0000, 2'b11, 32'h0000_2000, 32'h0000_0104, 32'h0000_2000};
    vecs[4] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'b00, 32'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_0200, 32'hFFFF_FFFF, 2'b00, 32'h0, 32'h0000_0204, 32'h0000_0204};
    vecs[6] = '{32'h0002_0000, 32'h0000_8000, 2'b01, 32'h0, 32'h0002_0004, 32'h0000_0004};
    vecs[7] = '{32'h0000_1000, 32'h03FF_FFFF, 2'b10, 32'h0, 32'h0000_1004, 32'h0FFF_FFFC};

    rst = 1'b1;
    stall = 1'b0;
    branch = 2'b00;
    reg_target = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // First fetch with zero-wait memory: FETCH in cycle 2, ISSUE in cycle 3
    rst = 1'b0;
    @(negedge clk);
    chk("boot_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("boot_addr", imem_bus.imem_addr, 32'h0);
    chk("boot_iv", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("first_iv", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, hashw(32'h0));
    chk("first_req", {31'd0, imem_bus.imem_req}, 32'd0);
    retire(2'b00, 32'h0, 0);
    chk("seq_addr4", imem_bus.imem_addr, 32'h4);
    wait_issue(ok);
    chk("seq_pc4", pc, 32'h4);
    retire(2'b00, 32'h0, 0);
    chk("seq_addr8", imem_bus.imem_addr, 32'h8);

    // Directed next-PC vectors: jr to the vector pc, then apply its branch
    lat = 1;
    for (int v = 0; v < 8; v++) begin
      wait_issue(ok);
      ovr_en = 1'b1;
      ovr_addr = vecs[v].pc;
      ovr_word = vecs[v].instr;
      retire(2'b11, vecs[v].pc, 0);
      chk($sformatf("vec%0d_setup", v), imem_bus.imem_addr, vecs[v].pc);
      wait_issue(ok);
      chk($sformatf("vec%0d_instr", v), instr, vecs[v].instr);
      chk($sformatf("vec%0d_pp4", v), pc_plus4, vecs[v].exp_pp4);
      retire(vecs[v].br, vecs[v].rt, 0);
      chk($sformatf("vec%0d_next", v), imem_bus.imem_addr, vecs[v].exp_next);
      chk($sformatf("vec%0d_err", v), {31'd0, err}, 32'd0);
      ovr_en = 1'b0;
    end

    // Three stall cycles hold the issue, then advance sequentially
    wait_issue(ok);
    p0 = pc;
    retire(2'b00, 32'h0, 3);
    chk("stall_adv_addr", imem_bus.imem_addr, p0 + 32'd4);
    chk("stall_adv_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // Randomized run against an address-level model
    do_reset();
    model_pc = 32'h0;
    for (int n = 0; n < 150; n++) begin
      lat = $urandom_range(0, 2);
      wait_issue(ok);
      if (!ok) break;
      iw = hashw(model_pc);
      chk("rnd_pc", pc, model_pc);
      chk("rnd_instr", instr, iw);
      chk("rnd_pp4", pc_plus4, model_pc + 32'd4);
      br = 2'($urandom);
      rt = $urandom & 32'hFFFF_FFFC;
      off = $signed(iw[15:0]);
      case (br)
        2'b00:   exp = model_pc + 32'd4;
        2'b01:   exp = model_pc + 32'd4 + 32'(off * 4);
        2'b10:   exp = ((model_pc + 32'd4) & 32'hF000_0000) | ({6'd0, iw[25:0]} << 2);
        default: exp = rt;
      endcase
      retire(br, rt, $urandom_range(0, 2));
      chk("rnd_next", imem_bus.imem_addr, exp);
      model_pc = exp;
    end
    chk("rnd_err", {31'd0, err}, 32'd0);

    // Misaligned register target halts with pc unchanged
    lat = 0;
    wait_issue(ok);
    p0 = pc;
    retire(2'b11, 32'h0000_2002, 0);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_pc", pc, p0);
    chk("mis_iv", {31'd0, instr_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mis_req", {31'd0, imem_bus.imem_req}, 32'd0);
      chk("mis_hold", {31'd0, halted}, 32'd1);
    end

    // Reset during an outstanding fetch; the late response is ignored
    do_reset();
    chk("post_halt_err", {31'd0, err}, 32'd0);
    wait_issue(ok);
    mem_en = 1'b0;
    retire(2'b11, 32'h0000_0300, 0);
    chk("rstf_addr", imem_bus.imem_addr, 32'h0000_0300);
    rst = 1'b1;
    #1;
    chk("rstf_req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rstf_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    force_valid = 1'b1;
    force_word = 32'hDEAD_BEEF;
    @(negedge clk);
    force_valid = 1'b0;
    chk("rstf_late_iv", {31'd0, instr_valid}, 32'd0);
    chk("rstf_late_instr", instr, 32'h0);
    chk("rstf_fetch_addr", imem_bus.imem_addr, 32'h0);
    mem_en = 1'b1;
    wait_issue(ok);
    chk("rstf_pc0", pc, 32'h0);
    chk("rstf_instr0", instr, hashw(32'h0));

    // Timeout after 4 FETCH cycles without a response
    mem_en = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_req", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("to_err_early", {31'd0, err}, 32'd0);
    end
    @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_req_off", {31'd0, imem_bus.imem_req}, 32'd0);
    mem_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_stays_halted", {31'd0, halted}, 32'd1);
    chk("to_no_issue", {31'd0, instr_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
